golden_nonce_collector: RTL and testbench
=========================================

Name: golden_nonce_collector

Overview:
- Collects golden-nonce hits from NCH parallel SHA-256 hasher channels.
- Corrects each hit by the pipeline offset and queues it in a DEPTH-entry FIFO.
- Drains the FIFO one nonce at a time to the MIPI TX path as a stretched write_enable pulse, gated by tx_busy.
- Replaces the single-channel, unbuffered golden_nonce/write_enable logic in the miner top level.

Parameters:
- NCH, 4: number of hasher channels (1..16).
- DEPTH_LOG2, 3: FIFO depth = 2^DEPTH_LOG2 entries of 32 bits.
- NONCE_OFFSET, 66: value subtracted from each raw hit nonce (66 for LOOP_LOG2=1; (1<<(7-LOOP_LOG2))+1 otherwise).
- WE_CYCLES, 16: write_enable high time per nonce, in clocks (1..255).

Ports:
- hash_clk, input, 1: sole clock.
- rst_n, input, 1: asynchronous active-low reset.
- job_load, input, 1: new work received; flushes pending hits and the FIFO.
- hit_valid, input, NCH: per-channel one-cycle golden-ticket strobe.
- hit_nonce, input, 32*NCH: raw nonce per channel; channel i is bits [32i+31:32i].
- tx_busy, input, 1: MIPI TX busy.
- nonce_out, output, 32: corrected nonce currently presented.
- write_enable, output, 1: nonce_out valid strobe to TX.
- fifo_count, output, DEPTH_LOG2+1: FIFO occupancy.
- drop_flag, output, 1: sticky; set when any hit is lost.

Behaviour:
- Reset values: nonce_out=0, write_enable=0, fifo_count=0, drop_flag=0, all pending regs clear, FSM=IDLE, round-robin pointer=0.
- Reset is asynchronous assert; all other logic is synchronous to hash_clk.
- Capture:
  - Each channel has a pending flag and a 32-bit register.
  - When hit_valid[i] is high and pending[i] is clear, set pending[i] and store hit_nonce_i - NONCE_OFFSET (mod 2^32, wraps).
  - When hit_valid[i] is high and pending[i] is already set, drop the new hit and set drop_flag.
- Arbitration:
  - Round-robin, one push per cycle.
  - Pick the first pending channel at or after pointer.
  - On a push, clear that channel's pending flag and set pointer = granted+1 mod NCH.
  - A channel captured in cycle t is eligible for push in cycle t+1. Minimum hit-to-FIFO latency: 2 clocks.
- FIFO:
  - Push only when not full.
  - When full, pending hits wait; they are not dropped, and further hits on those channels set drop_flag.
  - Simultaneous push and pop is allowed; fifo_count is unchanged.
- Drain FSM:
  - IDLE: if FIFO non-empty and tx_busy=0, pop into nonce_out, set write_enable=1, go to PULSE. nonce_out updates in the same cycle write_enable rises.
  - PULSE: count WE_CYCLES clocks with write_enable high, then drop write_enable and go to WAIT.
  - WAIT: stay until tx_busy=0, then return to IDLE.
  - nonce_out holds its value until the next pop.
  - With a continuously non-empty FIFO and tx_busy=0, consecutive write_enable pulses are separated by exactly 2 low cycles (WAIT, then IDLE).
- job_load (synchronous, highest priority):
  - Clears pending flags and empties the FIFO.
  - Forces FSM to IDLE and write_enable=0.
  - Hits arriving in the same cycle are discarded.
  - drop_flag is preserved; only rst_n clears it.

Optional Feature:
- Macro: GNC_DUP_FILTER_EN.
- Defined: keep a register holding the last pushed corrected nonce, plus a valid bit. A push whose value equals it is discarded without entering the FIFO; this is not a drop, and the channel's pending flag is still cleared. job_load and reset clear the valid bit.
- Undefined: every arbitrated hit is pushed. The register and comparator are not synthesised.

Test Plan:
- Single hit, NCH=4: hit_valid=0001, hit_nonce_0=0x00000100, tx_busy=0 -> nonce_out=0x000000BE, write_enable high exactly 16 clocks, fifo_count returns to 0.
- Wrap: hit_nonce_2=0x00000010 -> nonce_out=0xFFFFFFCE.
- Simultaneous hits: hit_valid=1111 with nonces 0x1000/0x2000/0x3000/0x4000 (+0x42 each) in one cycle -> four pulses in order ch0..ch3 with nonce_out 0x1000, 0x2000, 0x3000, 0x4000; drop_flag=0.
- Backpressure: tx_busy=1 while 9 hits arrive singly on ch0 -> fifo_count=8; the 9th stays pending. A 10th hit on ch0 sets drop_flag. After tx_busy=0, 9 pulses are emitted.
- job_load mid-PULSE with fifo_count=3 -> write_enable falls the next cycle, fifo_count=0, no further pulses; drop_flag is unchanged.
- With GNC_DUP_FILTER_EN: the same corrected nonce arriving on ch0 then ch1 -> one pulse only. Without the macro: two pulses.

Source files
------------

// File: rtl/golden_nonce_collector.sv
// golden_nonce_collector
//   Collects golden-nonce hits from NCH parallel hasher channels. Each hit is corrected by the
//   pipeline offset and parked in a per-channel pending register. A round-robin arbiter moves
//   one pending hit per cycle into a 2^DEPTH_LOG2 x 32 FIFO. A drain FSM presents each queued
//   nonce to the TX path as a write_enable pulse WE_CYCLES clocks long, gated by tx_busy.
//
// Ports
//   hash_clk      sole clock
//   rst_n         asynchronous active-low reset
//   job_load      new work: flush pending hits and FIFO, abort the current pulse
//   hit_valid     per-channel one-cycle hit strobe
//   hit_nonce     raw nonce per channel, channel i at [32i+31:32i]
//   tx_busy       TX path busy; blocks starting a pulse and holds the FSM in WAIT
//   nonce_out     corrected nonce currently presented (holds until the next pop)
//   write_enable  nonce_out valid strobe
//   fifo_count    FIFO occupancy
//   drop_flag     sticky; set when a hit is lost because its channel was still pending
//
// Optional feature (macro GNC_DUP_FILTER_EN): remember the last pushed nonce and discard an
// arbitrated hit with the same value instead of queueing it a second time.

module golden_nonce_collector #(
  parameter int unsigned NCH          = 4,
  parameter int unsigned DEPTH_LOG2   = 3,
  parameter int unsigned NONCE_OFFSET = 66,
  parameter int unsigned WE_CYCLES    = 16
) (
  input  logic                  hash_clk,
  input  logic                  rst_n,
  input  logic                  job_load,
  input  logic [NCH-1:0]        hit_valid,
  input  logic [32*NCH-1:0]     hit_nonce,
  input  logic                  tx_busy,
  output logic [31:0]           nonce_out,
  output logic                  write_enable,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  drop_flag
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned PtrW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {StIdle, StPulse, StWait} state_e;

  // Capture / arbitration state
  logic [NCH-1:0]        pending_q, pending_d;
  logic [31:0]           pend_nonce_q [NCH];
  logic [31:0]           pend_nonce_d [NCH];
  logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  drop_q, drop_d;

  // FIFO state
  logic [31:0]           mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;

  // Drain FSM state
  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [31:0]           nonce_out_q, nonce_out_d;
  logic [7:0]            pulse_cnt_q, pulse_cnt_d;

  logic                  gnt_found;
  logic [PtrW-1:0]       gnt_idx;
  logic [PtrW-1:0]       gnt_next;
  logic [31:0]           rr_idx;
  logic [31:0]           gnt_nonce;
  logic                  fifo_full;
  logic                  grant;
  logic                  is_dup;
  logic                  push;
  logic                  pop;

  // Round-robin search: first pending channel at or after rr_ptr_q.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rr_idx    = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      rr_idx = (32'(rr_ptr_q) + k) % NCH;
      if (!gnt_found && pending_q[rr_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_idx[PtrW-1:0];
      end
    end
  end

  assign gnt_next  = (gnt_idx == PtrW'(NCH - 1)) ? '0 : gnt_idx + PtrW'(1);
  assign gnt_nonce = pend_nonce_q[gnt_idx];
  assign fifo_full = (count_q == (DEPTH_LOG2 + 1)'(Depth));
  // A full FIFO stalls the arbiter; the pending hit simply waits.
  assign grant     = gnt_found && !fifo_full && !job_load;

`ifdef GNC_DUP_FILTER_EN
  logic [31:0] last_nonce_q;
  logic        last_valid_q;

  assign is_dup = last_valid_q && (last_nonce_q == gnt_nonce);

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_nonce_q <= '0;
      last_valid_q <= 1'b0;
    end else if (job_load) begin
      last_valid_q <= 1'b0;
    end else if (push) begin
      last_nonce_q <= gnt_nonce;
      last_valid_q <= 1'b1;
    end
  end
`else
  assign is_dup = 1'b0;
`endif

  // A duplicate still consumes the grant (pending cleared, pointer advanced) but is not queued.
  assign push = grant && !is_dup;

  // Capture and pending bookkeeping
  always_comb begin
    pending_d    = pending_q;
    pend_nonce_d = pend_nonce_q;
    rr_ptr_d     = rr_ptr_q;
    drop_d       = drop_q;
    if (job_load) begin
      pending_d = '0;
    end else begin
      if (grant) begin
        pending_d[gnt_idx] = 1'b0;
        rr_ptr_d           = gnt_next;
      end
      // Checked against pending_q: a channel being granted this cycle is still occupied.
      for (int unsigned i = 0; i < NCH; i++) begin
        if (hit_valid[i]) begin
          if (pending_q[i]) begin
            drop_d = 1'b1;
          end else begin
            pending_d[i]    = 1'b1;
            pend_nonce_d[i] = hit_nonce[32*i +: 32] - 32'(NONCE_OFFSET);
          end
        end
      end
    end
  end

  // Drain FSM
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    nonce_out_d = nonce_out_q;
    pulse_cnt_d = pulse_cnt_q;
    pop         = 1'b0;
    if (job_load) begin
      state_d     = StIdle;
      we_d        = 1'b0;
      pulse_cnt_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if ((count_q != '0) && !tx_busy) begin
            pop         = 1'b1;
            nonce_out_d = mem_q[rd_ptr_q];
            we_d        = 1'b1;
            pulse_cnt_d = '0;
            state_d     = StPulse;
          end
        end
        StPulse: begin
          if (pulse_cnt_q == 8'(WE_CYCLES - 1)) begin
            we_d    = 1'b0;
            state_d = StWait;
          end else begin
            pulse_cnt_d = pulse_cnt_q + 8'd1;
          end
        end
        StWait: begin
          if (!tx_busy) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (job_load) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      pend_nonce_q <= '{default: '0};
      rr_ptr_q     <= '0;
      drop_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= StIdle;
      we_q         <= 1'b0;
      nonce_out_q  <= '0;
      pulse_cnt_q  <= '0;
    end else begin
      pending_q    <= pending_d;
      pend_nonce_q <= pend_nonce_d;
      rr_ptr_q     <= rr_ptr_d;
      drop_q       <= drop_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      we_q         <= we_d;
      nonce_out_q  <= nonce_out_d;
      pulse_cnt_q  <= pulse_cnt_d;
    end
  end

  // Storage needs no reset; occupancy tracking guards every read.
  always_ff @(posedge hash_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= gnt_nonce;
    end
  end

  assign nonce_out    = nonce_out_q;
  assign write_enable = we_q;
  assign fifo_count   = count_q;
  assign drop_flag    = drop_q;

endmodule

// File: tb/tb_golden_nonce_collector.sv
// Directed bench for golden_nonce_collector with default parameters
// (NCH=4, DEPTH_LOG2=3, NONCE_OFFSET=66, WE_CYCLES=16).
// Inputs are driven and outputs sampled on the falling edge of hash_clk.

module tb_golden_nonce_collector;

  logic         hash_clk;
  logic         rst_n;
  logic         job_load;
  logic [3:0]   hit_valid;
  logic [127:0] hit_nonce;
  logic         tx_busy;
  logic [31:0]  nonce_out;
  logic         write_enable;
  logic [3:0]   fifo_count;
  logic         drop_flag;

  int n_cmp;
  int n_fail;

  golden_nonce_collector dut (
    .hash_clk     (hash_clk),
    .rst_n        (rst_n),
    .job_load     (job_load),
    .hit_valid    (hit_valid),
    .hit_nonce    (hit_nonce),
    .tx_busy      (tx_busy),
    .nonce_out    (nonce_out),
    .write_enable (write_enable),
    .fifo_count   (fifo_count),
    .drop_flag    (drop_flag)
  );

  initial hash_clk = 1'b0;
  always #5 hash_clk = ~hash_clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge hash_clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  // One-cycle hit on channel ch; returns one falling edge later.
  task automatic hit_one(input int ch, input logic [31:0] raw);
    hit_valid[ch]         = 1'b1;
    hit_nonce[32*ch +: 32] = raw;
    @(negedge hash_clk);
    hit_valid = '0;
  endtask

  // Waits (bounded) for write_enable, records nonce, high time and low cycles before it.
  task automatic capture_pulse(output logic [31:0] n, output int len, output int gap,
                               output bit ok);
    ok  = 1'b0;
    n   = '0;
    len = 0;
    gap = 0;
    while (!write_enable && gap < 500) begin
      gap++;
      @(negedge hash_clk);
    end
    if (write_enable) begin
      ok = 1'b1;
      n  = nonce_out;
      while (write_enable && len < 300) begin
        len++;
        @(negedge hash_clk);
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    job_load  = 1'b0;
    hit_valid = '0;
    hit_nonce = '0;
    tx_busy   = 1'b0;
    step(2);
    n_cmp++; if (nonce_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_nonce_out got=%h exp=%h", nonce_out, 32'h0);
    end
    n_cmp++; if (write_enable !== 1'b0) begin
      n_fail++; $display("FAIL reset_we got=%b exp=0", write_enable);
    end
    n_cmp++; if (fifo_count !== 4'd0) begin
      n_fail++; $display("FAIL reset_count got=%0d exp=0", fifo_count);
    end
    n_cmp++; if (drop_flag !== 1'b0) begin
      n_fail++; $display("FAIL reset_drop got=%b exp=0", drop_flag);
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_single();
    logic [31:0] n;
    int len, gap;
    bit ok;
    hit_one(0, 32'h0000_0100);
    @(negedge hash_clk);
    n_cmp++; if (fifo_count !== 4'd1 || write_enable !== 1'b0) begin
      n_fail++; $display("FAIL single_latency got count=%0d we=%b exp count=1 we=0",
                         fifo_count, write_enable);
    end
    capture_pulse(n, len, gap, ok);
    n_cmp++; if (!ok || n !== 32'h0000_00BE) begin
      n_fail++; $display("FAIL single_nonce got=%h ok=%b exp=000000be", n, ok);
    end
    n_cmp++; if (len !== 16) begin
      n_fail++; $display("FAIL single_len got=%0d exp=16", len);
    end
    n_cmp++; if (gap !== 1) begin
      n_fail++; $display("FAIL single_rise got=%0d exp=1", gap);
    end
    step(3);
    n_cmp++; if (fifo_count !== 4'd0) begin
      n_fail++; $display("FAIL single_count got=%0d exp=0", fifo_count);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] n;
    int len, gap;
    bit ok;
    hit_one(2, 32'h0000_0010);
    capture_pulse(n, len, gap, ok);
    n_cmp++; if (!ok || n !== 32'hFFFF_FFCE) begin
      n_fail++; $display("FAIL wrap_nonce got=%h ok=%b exp=ffffffce", n, ok);
    end
    step(4);
  endtask

  task automatic test_simultaneous();
    logic [31:0] n;
    int len, gap;
    bit ok;
    logic [31:0] exp_n [4];
    exp_n = '{32'h1000, 32'h2000, 32'h3000, 32'h4000};
    do_reset();
    for (int c = 0; c < 4; c++) hit_nonce[32*c +: 32] = exp_n[c] + 32'h42;
    hit_valid = 4'b1111;
    @(negedge hash_clk);
    hit_valid = '0;
    for (int p = 0; p < 4; p++) begin
      capture_pulse(n, len, gap, ok);
      n_cmp++; if (!ok || n !== exp_n[p]) begin
        n_fail++; $display("FAIL simul_nonce%0d got=%h ok=%b exp=%h", p, n, ok, exp_n[p]);
      end
      n_cmp++; if (len !== 16) begin
        n_fail++; $display("FAIL simul_len%0d got=%0d exp=16", p, len);
      end
      if (p > 0) begin
        n_cmp++; if (gap !== 2) begin
          n_fail++; $display("FAIL simul_gap%0d got=%0d exp=2", p, gap);
        end
      end
    end
    n_cmp++; if (drop_flag !== 1'b0) begin
      n_fail++; $display("FAIL simul_drop got=%b exp=0", drop_flag);
    end
    step(4);
  endtask

  task automatic test_backpressure();
    logic [31:0] n;
    int len, gap;
    bit ok;
    do_reset();
    tx_busy = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      hit_one(0, 32'h42 + 32'(k));
      step(1);
    end
    step(2);
    n_cmp++; if (fifo_count !== 4'd8) begin
      n_fail++; $display("FAIL bp_full got=%0d exp=8", fifo_count);
    end
    n_cmp++; if (drop_flag !== 1'b0) begin
      n_fail++; $display("FAIL bp_nodrop got=%b exp=0", drop_flag);
    end
    hit_one(0, 32'h42 + 32'd100);
    step(1);
    n_cmp++; if (drop_flag !== 1'b1) begin
      n_fail++; $display("FAIL bp_drop got=%b exp=1", drop_flag);
    end
    n_cmp++; if (fifo_count !== 4'd8) begin
      n_fail++; $display("FAIL bp_still_full got=%0d exp=8", fifo_count);
    end
    tx_busy = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      capture_pulse(n, len, gap, ok);
      n_cmp++; if (!ok || n !== 32'(k)) begin
        n_fail++; $display("FAIL bp_nonce%0d got=%h ok=%b exp=%h", k, n, ok, 32'(k));
      end
    end
    len = 0;
    for (int i = 0; i < 40; i++) begin
      if (write_enable) len++;
      @(negedge hash_clk);
    end
    n_cmp++; if (len !== 0 || fifo_count !== 4'd0) begin
      n_fail++; $display("FAIL bp_extra got we_cycles=%0d count=%0d exp 0/0", len, fifo_count);
    end
  endtask

  task automatic test_job_load();
    int hi, guard;
    tx_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      hit_one(0, 32'h52 + 32'(k));
      step(1);
    end
    step(2);
    n_cmp++; if (fifo_count !== 4'd4) begin
      n_fail++; $display("FAIL jl_fill got=%0d exp=4", fifo_count);
    end
    tx_busy = 1'b0;
    guard = 0;
    while (!write_enable && guard < 50) begin
      guard++;
      @(negedge hash_clk);
    end
    step(3);
    n_cmp++; if (write_enable !== 1'b1 || fifo_count !== 4'd3) begin
      n_fail++; $display("FAIL jl_mid got we=%b count=%0d exp we=1 count=3",
                         write_enable, fifo_count);
    end
    job_load = 1'b1;
    @(negedge hash_clk);
    job_load = 1'b0;
    n_cmp++; if (write_enable !== 1'b0 || fifo_count !== 4'd0) begin
      n_fail++; $display("FAIL jl_flush got we=%b count=%0d exp we=0 count=0",
                         write_enable, fifo_count);
    end
    hi = 0;
    for (int i = 0; i < 60; i++) begin
      if (write_enable) hi++;
      @(negedge hash_clk);
    end
    n_cmp++; if (hi !== 0) begin
      n_fail++; $display("FAIL jl_quiet got=%0d exp=0", hi);
    end
    n_cmp++; if (drop_flag !== 1'b1) begin
      n_fail++; $display("FAIL jl_drop_kept got=%b exp=1", drop_flag);
    end
  endtask

  task automatic test_dup();
    int pulses, exp_pulses;
    logic prev_we;
    logic [31:0] first_n;
`ifdef GNC_DUP_FILTER_EN
    exp_pulses = 1;
`else
    exp_pulses = 2;
`endif
    hit_one(0, 32'h5042);
    hit_one(1, 32'h5042);
    pulses  = 0;
    prev_we = 1'b0;
    first_n = '0;
    for (int i = 0; i < 100; i++) begin
      if (write_enable && !prev_we) begin
        if (pulses == 0) first_n = nonce_out;
        pulses++;
      end
      prev_we = write_enable;
      @(negedge hash_clk);
    end
    n_cmp++; if (pulses !== exp_pulses) begin
      n_fail++; $display("FAIL dup_pulses got=%0d exp=%0d", pulses, exp_pulses);
    end
    n_cmp++; if (first_n !== 32'h5000) begin
      n_fail++; $display("FAIL dup_nonce got=%h exp=00005000", first_n);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_wrap();
    test_simultaneous();
    test_backpressure();
    test_job_load();
    test_dup();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
